lfsr_word_arbiter: RTL and testbench



---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr.sv | 40 ++++
 rtl/lfsr_word_arbiter.sv | 116 +++++++++++
 tb/tb_lfsr_word_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR word arbiter slice.
// Holds the arbiter FSM encoding and the zero-seed substitute.
package lfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEED,
      ST_SHIFT,
      ST_RESP
   } lfsr_arb_state_t;

   localparam int MaxDepth = 64;

   // An all-zero state would lock the generator, so map it to 1.
   function automatic logic [MaxDepth-1:0] nonzero_seed(
      input logic [MaxDepth-1:0] s
   );
      return (s == '0) ? MaxDepth'(1) : s;
   endfunction

endpackage

// File: rtl/lfsr.sv
// Shared Galois/Fibonacci LFSR with synchronous load.
// Output bit is state[0]; reset state is 1.
module lfsr #(
   parameter int               Depth  = 8,
   parameter logic [Depth-1:0] Coeffs = 8'hB8,
   parameter bit               Galois = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             set_state,
   input  logic [Depth-1:0] seed,
   output logic             out
);

   logic [Depth-1:0] state;
   logic [Depth-1:0] nxt;

   always_comb begin
      nxt = state >> 1;
      if (Galois) begin
         if (state[0]) nxt = nxt ^ Coeffs;
      end else begin
         nxt[Depth-1] = ^(state & Coeffs);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= Depth'(1);
      end else if (set_state) begin
         state <= seed;
      end else if (enable) begin
         state <= nxt;
      end
   end

   assign out = state[0];

endmodule

// File: rtl/lfsr_word_arbiter.sv
// Round-robin arbiter sharing one LFSR among requesters of
// WordWidth-bit random words; also sequences reseeding.
module lfsr_word_arbiter
   import lfsr_pkg::*;
#(
   parameter int               NumReq    = 4,
   parameter int               WordWidth = 8,
   parameter int               Depth     = 8,
   parameter logic [Depth-1:0] Coeffs    = 8'hB8,
   parameter bit               Galois    = 1'b1,
   localparam int              IdWidth   = $clog2(NumReq)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NumReq-1:0]    req_valid,
   output logic [NumReq-1:0]    req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IdWidth-1:0]   rsp_id,
   output logic [WordWidth-1:0] rsp_data,
   input  logic                 seed_valid,
   input  logic [Depth-1:0]     seed_data,
   output logic                 seed_ready,
   output logic                 busy
);

   localparam int CntWidth = $clog2(WordWidth + 1);
   localparam logic [CntWidth-1:0] LastBit = CntWidth'(WordWidth - 1);

   lfsr_arb_state_t     state;
   logic [IdWidth-1:0]  last_grant;
   logic [IdWidth-1:0]  grant;
   logic [CntWidth-1:0] cnt;
   logic                take_req;
   logic                lfsr_out;
   logic [Depth-1:0]    seed_fix;

   function automatic logic [IdWidth-1:0] rr_pick(
      input logic [NumReq-1:0]  v,
      input logic [IdWidth-1:0] last
   );
      logic [IdWidth-1:0] pick;
      logic               found;
      int                 idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= NumReq; i++) begin
         idx = (int'(last) + i) % NumReq;
         if (!found && v[idx]) begin
            pick  = IdWidth'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      grant     = rr_pick(req_valid, last_grant);
      take_req  = (state == ST_IDLE) && !seed_valid && (|req_valid);
      req_ready = '0;
      if (take_req) req_ready[grant] = 1'b1;
   end

   assign seed_ready = (state == ST_SEED);
   assign rsp_valid  = (state == ST_RESP);
   assign busy       = (state != ST_IDLE);
   assign seed_fix   = Depth'(nonzero_seed(MaxDepth'(seed_data)));

   lfsr #(
      .Depth (Depth),
      .Coeffs(Coeffs),
      .Galois(Galois)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .enable   (state == ST_SHIFT),
      .set_state(state == ST_SEED),
      .seed     (seed_fix),
      .out      (lfsr_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= IdWidth'(NumReq - 1);
         rsp_id     <= '0;
         rsp_data   <= '0;
         cnt        <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (seed_valid) begin
                  state <= ST_SEED;
               end else if (take_req) begin
                  last_grant <= grant;
                  rsp_id     <= grant;
                  cnt        <= '0;
                  state      <= ST_SHIFT;
               end
            end
            ST_SEED: state <= ST_IDLE;
            // Bit k is sampled before this cycle's advance.
            ST_SHIFT: begin
               rsp_data[cnt] <= lfsr_out;
               cnt           <= cnt + CntWidth'(1);
               if (cnt == LastBit) state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Self-checking bench for lfsr_word_arbiter: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_lfsr_word_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_valid;
   logic [3:0] req_ready;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [1:0] rsp_id;
   logic [7:0] rsp_data;
   logic       seed_valid;
   logic [7:0] seed_data;
   logic       seed_ready;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   lfsr_word_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .seed_valid(seed_valid),
      .seed_data (seed_data),
      .seed_ready(seed_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: a word is the next 8 generator bits,
   // drawn in one go when the request is granted.
   bit         started = 0;
   bit         m_seed, m_resp, m_idle;
   int         m_left, m_last;
   logic [1:0] m_id;
   logic [7:0] m_word, m_lfsr;
   logic [3:0] exp_rr;

   function automatic int pick(input logic [3:0] v, input int last);
      int g;
      g = -1;
      for (int off = 1; off <= 4; off++)
         if (g < 0 && v[(last + off) % 4]) g = (last + off) % 4;
      return g;
   endfunction

   task automatic model_step();
      int g;
      m_idle = !m_seed && m_left == 0 && !m_resp;
      exp_rr = '0;
      if (m_idle && !seed_valid && req_valid != 0)
         exp_rr[pick(req_valid, m_last)] = 1'b1;
      if (started) begin
         chk("req_ready", req_ready, exp_rr);
         chk("seed_ready", seed_ready, m_seed);
         chk("rsp_valid", rsp_valid, m_resp);
         chk("busy", busy, !m_idle);
         chk("rsp_id", rsp_id, m_id);
         if (m_resp) chk("rsp_data", rsp_data, m_word);
      end
      if (reset) begin
         m_seed = 0; m_left = 0; m_resp = 0;
         m_last = 3; m_id = 0; m_lfsr = 8'h01;
         started = 1;
      end else if (started) begin
         if (m_idle) begin
            if (seed_valid) begin
               m_seed = 1;
            end else if (req_valid != 0) begin
               g = pick(req_valid, m_last);
               m_last = g;
               m_id = 2'(g);
               for (int k = 0; k < 8; k++) begin
                  m_word[k] = m_lfsr[0];
                  m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
               end
               m_left = 8;
            end
         end else if (m_seed) begin
            m_lfsr = (seed_data == 0) ? 8'h01 : seed_data;
            m_seed = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_resp = 1;
         end else if (m_resp && rsp_ready) begin
            m_resp = 0;
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string name);
      chk(name, {req_ready, seed_ready, rsp_valid, rsp_data,
                 rsp_id, busy}, 0);
   endtask

   task automatic do_reset();
      reset = 1; req_valid = 0; seed_valid = 0;
      tick(); tick();
      reset = 0;
      @(negedge clk);
      check_reset("reset_state");
      tick();
   endtask

   task automatic wait_accept(output int g, output int t);
      g = -1; t = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
            t = cyc;
            break;
         end
      end
      if (g < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output logic [7:0] d, output logic [1:0] id,
                           output int t);
      bit ok;
      ok = 0; d = 0; id = 0; t = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            d = rsp_data; id = rsp_id; t = cyc; ok = 1;
            break;
         end
      end
      if (!ok) chk("rsp_timeout", 0, 1);
   endtask

   initial begin
      int         g, t0, t1, tp, ts;
      logic [7:0] d;
      logic [1:0] id;
      bit         seen, early;
      logic [3:0] rr;
      logic       sr;

      reset = 1; req_valid = 0; rsp_ready = 0;
      seed_valid = 0; seed_data = 0;
      do_reset();

      // Single request after reset.
      req_valid = 4'b0001; rsp_ready = 1;
      wait_accept(g, t0);
      chk("t1_grant", g, 0);
      tick(); req_valid = 0;
      wait_rsp(d, id, t1);
      chk("t1_latency", t1 - t0, 9);
      chk("t1_word", d, 8'h71);
      chk("t1_id", id, 0);
      tick();

      // All requesters continuously.
      do_reset();
      req_valid = 4'hF;
      tp = 0;
      for (int i = 0; i < 5; i++) begin
         wait_accept(g, t0);
         chk("t2_grant", g, i % 4);
         if (i > 0) chk("t2_spacing", t0 - tp, 10);
         tp = t0;
      end
      tick(); req_valid = 0;
      wait_rsp(d, id, t1);
      chk("t2_last_id", id, 0);
      tick();

      // Zero seed and request in the same cycle.
      do_reset();
      seed_valid = 1; seed_data = 8'h00; req_valid = 4'b0001;
      t0 = cyc; seen = 0; early = 0; ts = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (req_ready != 0) early = 1;
         if (seed_ready) begin seen = 1; ts = cyc; end
      end
      chk("t3_seed_seen", seen, 1);
      chk("t3_req_not_first", early, 0);
      chk("t3_seed_latency", ts - t0, 1);
      tick(); seed_valid = 0;
      wait_accept(g, t0);
      chk("t3_grant", g, 0);
      tick(); req_valid = 0;
      wait_rsp(d, id, t1);
      chk("t3_word", d, 8'h71);
      tick();

      // Back-pressure on the response channel.
      rsp_ready = 0; req_valid = 4'b0010;
      wait_accept(g, t0);
      chk("t4_grant", g, 1);
      tick(); req_valid = 0;
      wait_rsp(d, id, t1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_busy", {busy, rsp_valid}, 2'b11);
         chk("t4_hold_data", {rsp_id, rsp_data}, {id, d});
      end
      tick(); rsp_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("t4_idle_after", busy, 0);
      tick();

      // Reset during SHIFT cycle 4.
      req_valid = 4'b0001;
      wait_accept(g, t0);
      tick(); req_valid = 0;
      repeat (4) tick();
      reset = 1;
      tick(); reset = 0;
      @(negedge clk);
      check_reset("t5_reset_state");
      tick();
      req_valid = 4'b0001;
      wait_accept(g, t0);
      chk("t5_grant", g, 0);
      tick(); req_valid = 0;
      wait_rsp(d, id, t1);
      chk("t5_word", d, 8'h71);
      tick();

      // Seed arriving mid-word waits for the handshake.
      req_valid = 4'b0001;
      wait_accept(g, t0);
      tick(); req_valid = 0;
      tick(); seed_valid = 1; seed_data = 8'h5A;
      seen = 0; ts = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (seed_ready) begin seen = 1; ts = cyc; end
      end
      chk("t6_seed_seen", seen, 1);
      chk("t6_seed_time", ts - t0, 11);
      tick(); seed_valid = 0;

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rr = req_ready; sr = seed_ready;
         tick();
         req_valid = req_valid & ~rr;
         if (sr) seed_valid = 0;
         for (int k = 0; k < 4; k++) begin
            if (!req_valid[k] && $urandom_range(7) == 0)
               req_valid[k] = 1'b1;
            else if (req_valid[k] && $urandom_range(63) == 0)
               req_valid[k] = 1'b0;
         end
         if (!seed_valid && $urandom_range(40) == 0) begin
            seed_valid = 1;
            seed_data = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
         end
         rsp_ready = ($urandom_range(2) != 0);
         reset = ($urandom_range(400) == 0);
      end
      reset = 0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
